// File: rtl/add2_dft_pkg.sv
// add2_dft_pkg -- shared definitions for the add2 DFT wrapper logic.
//   state_e      : BIST controller states (IDLE, SEED, RUN, SIGN, DONE)
//   LFSR_W/MISR_W: pattern generator / signature register widths
//   *_TAPS       : feedback tap masks (x^5+x^3+1 and x^3+x^2+1)
//   lfsr_next/misr_next : one-step update helpers
package add2_dft_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEED,
        ST_RUN,
        ST_SIGN,
        ST_DONE
    } state_e;

    localparam int LFSR_W = 5;
    localparam int MISR_W = 3;

    // Feedback is the XOR of the bits selected by the mask, shifted into bit 0.
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 5'b10100;  // lfsr[4]^lfsr[2]
    localparam logic [MISR_W-1:0] MISR_TAPS = 3'b110;    // misr[2]^misr[1]

    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] l);
        return {l[LFSR_W-2:0], ^(l & LFSR_TAPS)};
    endfunction

    function automatic logic [MISR_W-1:0] misr_next(input logic [MISR_W-1:0] m,
                                                    input logic [MISR_W-1:0] d);
        return {m[MISR_W-2:0], ^(m & MISR_TAPS)} ^ d;
    endfunction

endpackage

// File: rtl/add2_bist_ctrl_if.sv
// add2_bist_ctrl_if -- bus between system logic, the BIST controller and the
// add2 CUT.
//   start     : begin a test run (system -> ctrl)
//   func_in   : functional CUT stimulus {N5..N1} (system -> ctrl)
//   cut_out   : CUT response {N52,N51,N50} (CUT -> ctrl)
//   cut_in    : CUT stimulus (ctrl -> CUT)
//   func_gnt  : functional path owns the CUT
//   busy/done/pass/signature : test status
// Modports: slave = the controller, master = the system/CUT side.
interface add2_bist_ctrl_if;
    import add2_dft_pkg::*;

    logic              start;
    logic [LFSR_W-1:0] func_in;
    logic [MISR_W-1:0] cut_out;
    logic [LFSR_W-1:0] cut_in;
    logic              func_gnt;
    logic              busy;
    logic              done;
    logic              pass;
    logic [MISR_W-1:0] signature;

    modport slave (
        input  start, func_in, cut_out,
        output cut_in, func_gnt, busy, done, pass, signature
    );

    modport master (
        output start, func_in, cut_out,
        input  cut_in, func_gnt, busy, done, pass, signature
    );

endinterface

// File: rtl/add2_misr.sv
// add2_misr -- 3-bit multiple-input signature register (x^3+x^2+1).
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset, clears the signature
//   clr   : synchronous clear (start of a run)
//   en    : compact d into the signature this cycle
//   d     : parallel response input
//   q     : current signature
module add2_misr
    import add2_dft_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              en,
    input  logic [MISR_W-1:0] d,
    output logic [MISR_W-1:0] q
);

    logic [MISR_W-1:0] r_sig;

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            r_sig <= '0;
        end else if (en) begin
            r_sig <= misr_next(r_sig, d);
        end
    end

    assign q = r_sig;

endmodule

// File: rtl/add2_bist_ctrl.sv
// add2_bist_ctrl -- BIST controller and CUT access arbiter for add2.
// Functional mode passes func_in to the CUT; a test run applies N_PAT LFSR
// patterns, compacts the responses in a MISR and compares against GOLDEN.
// Ports:
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset (aborts any run)
//   bus   : add2_bist_ctrl_if.slave (start, func_in, cut_out in;
//           cut_in, func_gnt, busy, done, pass, signature out)
// Parameters: N_PAT (1..255), SEED (non-zero), GOLDEN.
// Build option: ADD2_BIST_ALLZERO_EN appends one all-zero pattern after the
// LFSR patterns (latency N_PAT+4 instead of N_PAT+3).
module add2_bist_ctrl
    import add2_dft_pkg::*;
#(
    parameter int unsigned       N_PAT  = 31,
    parameter logic [LFSR_W-1:0] SEED   = 5'b00001,
    parameter logic [MISR_W-1:0] GOLDEN = 3'b000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    add2_bist_ctrl_if.slave      bus
);

`ifdef ADD2_BIST_ALLZERO_EN
    // The extra zero pattern is applied while pat_cnt == N_PAT.
    localparam logic [7:0] LAST_CNT = 8'(N_PAT);
`else
    localparam logic [7:0] LAST_CNT = 8'(N_PAT - 1);
`endif

    state_e            r_state;
    state_e            w_state_nxt;
    logic [LFSR_W-1:0] r_lfsr;
    logic [7:0]        r_pat_cnt;
    logic              r_pass;
    logic              w_misr_clr;
    logic              w_misr_en;
    logic              w_zero_pat;
    logic              w_owned;
    logic [MISR_W-1:0] w_sig;

`ifdef ADD2_BIST_ALLZERO_EN
    assign w_zero_pat = (r_pat_cnt == LAST_CNT);
`else
    assign w_zero_pat = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_misr_clr  = 1'b0;
        w_misr_en   = 1'b0;
        unique case (r_state)
            ST_IDLE: if (bus.start) w_state_nxt = ST_SEED;
            ST_SEED: begin
                w_misr_clr  = 1'b1;
                w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                w_misr_en = 1'b1;
                if (r_pat_cnt == LAST_CNT) w_state_nxt = ST_SIGN;
            end
            ST_SIGN: w_state_nxt = ST_DONE;
            ST_DONE: if (bus.start) w_state_nxt = ST_SEED;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_lfsr    <= SEED;
            r_pat_cnt <= '0;
            r_pass    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                ST_SEED: begin
                    r_lfsr    <= SEED;
                    r_pat_cnt <= '0;
                    r_pass    <= 1'b0;
                end
                ST_RUN: begin
                    r_lfsr    <= lfsr_next(r_lfsr);
                    r_pat_cnt <= r_pat_cnt + 8'd1;
                end
                ST_SIGN: r_pass <= (w_sig == GOLDEN);
                default: ;
            endcase
        end
    end

    add2_misr u_misr (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (w_misr_clr),
        .en   (w_misr_en),
        .d    (bus.cut_out),
        .q    (w_sig)
    );

    // The CUT is held from SEED through SIGN even though only RUN drives
    // test patterns, so functional users see one contiguous busy window.
    assign w_owned      = (r_state == ST_SEED) || (r_state == ST_RUN) || (r_state == ST_SIGN);
    assign bus.cut_in   = (r_state == ST_RUN) ? (w_zero_pat ? '0 : r_lfsr) : bus.func_in;
    assign bus.func_gnt = !w_owned;
    assign bus.busy     = w_owned;
    assign bus.done     = (r_state == ST_DONE);
    assign bus.pass     = r_pass;
    assign bus.signature = w_sig;

endmodule

// File: tb/tb_add2_bist_ctrl.sv
module tb_add2_bist_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] func_in;
    logic [2:0] cut_out;
    logic [2:0] start_v;

    int n_cmp = 0;
    int n_bad = 0;
    logic [4:0] exp_q[$];

    always #5 clk = ~clk;

    add2_bist_ctrl_if bus0 ();
    add2_bist_ctrl_if bus1 ();
    add2_bist_ctrl_if bus2 ();

    assign bus0.start = start_v[0];
    assign bus1.start = start_v[1];
    assign bus2.start = start_v[2];
    assign bus0.func_in = func_in;
    assign bus1.func_in = func_in;
    assign bus2.func_in = func_in;
    assign bus0.cut_out = cut_out;
    assign bus1.cut_out = cut_out;
    assign bus2.cut_out = cut_out;

    add2_bist_ctrl #(.N_PAT(4), .SEED(5'b00001), .GOLDEN(3'b000))
        u_dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
    add2_bist_ctrl #(.N_PAT(3), .SEED(5'b00001), .GOLDEN(3'b110))
        u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
    add2_bist_ctrl #(.N_PAT(3), .SEED(5'b00001), .GOLDEN(3'b000))
        u_dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

    logic [4:0] o_cut_in [3];
    logic [2:0] o_sig    [3];
    logic       o_gnt    [3];
    logic       o_busy   [3];
    logic       o_done   [3];
    logic       o_pass   [3];

    assign o_cut_in[0] = bus0.cut_in;   assign o_cut_in[1] = bus1.cut_in;   assign o_cut_in[2] = bus2.cut_in;
    assign o_sig[0]    = bus0.signature; assign o_sig[1]   = bus1.signature; assign o_sig[2]   = bus2.signature;
    assign o_gnt[0]    = bus0.func_gnt; assign o_gnt[1]    = bus1.func_gnt; assign o_gnt[2]    = bus2.func_gnt;
    assign o_busy[0]   = bus0.busy;     assign o_busy[1]   = bus1.busy;     assign o_busy[2]   = bus2.busy;
    assign o_done[0]   = bus0.done;     assign o_done[1]   = bus1.done;     assign o_done[2]   = bus2.done;
    assign o_pass[0]   = bus0.pass;     assign o_pass[1]   = bus1.pass;     assign o_pass[2]   = bus2.pass;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Reference models written from the polynomial definitions.
    function automatic logic [4:0] m_lfsr(input logic [4:0] l);
        return {l[3:0], l[4] ^ l[2]};
    endfunction

    function automatic logic [2:0] m_misr(input logic [2:0] m, input logic [2:0] d);
        return {m[1:0], m[2] ^ m[1]} ^ d;
    endfunction

    // One full test run on DUT k; optionally re-pulses start during RUN.
    task automatic run_test(input int k, input int npat, input logic [2:0] golden,
                            input bit restart);
        logic [4:0] l;
        logic [2:0] sig;
        logic [4:0] got;
        int n_run;
        int lat;
        l   = 5'b00001;
        sig = 3'b000;
        for (int i = 0; i < npat; i++) begin
            exp_q.push_back(l);
            sig = m_misr(sig, cut_out);
            l   = m_lfsr(l);
        end
        n_run = npat;
`ifdef ADD2_BIST_ALLZERO_EN
        exp_q.push_back(5'b00000);
        sig   = m_misr(sig, cut_out);
        n_run = npat + 1;
`endif
        @(negedge clk);
        start_v[k] = 1'b1;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        start_v[k] = 1'b0;
        // SEED cycle
        chk("seed_gnt", o_gnt[k], 0);
        chk("seed_busy", o_busy[k], 1);
        chk("seed_done", o_done[k], 0);
        for (int c = 1; c <= n_run + 1; c++) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            start_v[k] = restart && (c == 1);
            chk("run_gnt", o_gnt[k], 0);
            chk("run_busy", o_busy[k], 1);
            chk("run_done", o_done[k], 0);
            if (c <= n_run) begin
                chk("run_pass", o_pass[k], 0);
                if (exp_q.size() > 0) begin
                    got = o_cut_in[k];
                    chk("cut_in", got, exp_q.pop_front());
                end else begin
                    chk("q_underflow", 1, 0);
                end
            end
        end
        start_v[k] = 1'b0;
        while (!o_done[k] && lat < npat + 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        chk("latency", lat, n_run + 3);
        chk("done", o_done[k], 1);
        chk("done_gnt", o_gnt[k], 1);
        chk("done_busy", o_busy[k], 0);
        chk("signature", o_sig[k], sig);
        chk("pass", o_pass[k], (sig == golden));
        chk("q_empty", exp_q.size(), 0);
        exp_q.delete();
        got = o_cut_in[k];
        chk("done_cut_in", got, func_in);
        // DONE holds its results.
        @(negedge clk);
        chk("hold_done", o_done[k], 1);
        chk("hold_sig", o_sig[k], sig);
        chk("hold_pass", o_pass[k], (sig == golden));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n   = 1'b0;
        start_v = 3'b000;
        func_in = 5'b10110;
        cut_out = 3'b001;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk("rst_gnt", o_gnt[k], 1);
            chk("rst_busy", o_busy[k], 0);
            chk("rst_done", o_done[k], 0);
            chk("rst_pass", o_pass[k], 0);
            chk("rst_sig", o_sig[k], 0);
            chk("rst_cut_in", o_cut_in[k], 5'b10110);
        end
        rst_n = 1'b1;

        run_test(0, 4, 3'b000, 1'b0);
        run_test(1, 3, 3'b110, 1'b0);
        run_test(2, 3, 3'b000, 1'b0);
        run_test(0, 4, 3'b000, 1'b1);
        run_test(1, 3, 3'b110, 1'b1);

        // Mid-run reset: assert during the second RUN cycle.
        @(negedge clk);
        start_v[0] = 1'b1;
        @(posedge clk);          // -> SEED
        @(negedge clk);
        start_v[0] = 1'b0;
        @(posedge clk);          // -> RUN (1st)
        @(posedge clk);          // -> RUN (2nd)
        @(negedge clk);
        chk("mid_busy_pre", o_busy[0], 1);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("mid_gnt", o_gnt[0], 1);
        chk("mid_busy", o_busy[0], 0);
        chk("mid_done", o_done[0], 0);
        chk("mid_sig", o_sig[0], 0);
        chk("mid_cut_in", o_cut_in[0], func_in);
        rst_n = 1'b1;

        func_in = 5'b01101;
        run_test(0, 4, 3'b000, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
